// File: rtl/mash111_acc_chain_pkg.sv
// Shared types and constants for the MASH 1-1-1 accumulator chain.
package mash111_acc_chain_pkg;
  localparam int ACC_W  = 16;
  localparam int LFSR_W = 15;
  localparam int OP_W   = 4;
  localparam int STAGES = 3;

  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic [OP_W-1:0]   nc_op_t;

  localparam lfsr_t LFSR_SEED = 15'h4A3F;

  typedef struct packed {
    nc_op_t add1;
    nc_op_t add2;
    nc_op_t minus;
  } nc_ops_t;

  // x^15 + x^14 + 1, shifting towards bit 0; bit 0 is the dither output
  function automatic lfsr_t lfsr_next(lfsr_t s);
    return {s[0] ^ s[1], s[LFSR_W-1:1]};
  endfunction

  // a + b or a + 2*b on single carry bits, widened to the operand width
  function automatic nc_op_t carry_sum(logic a, logic b, logic b_x2);
    nc_op_t bw;
    bw = b_x2 ? {{(OP_W-2){1'b0}}, b, 1'b0} : {{(OP_W-1){1'b0}}, b};
    return {{(OP_W-1){1'b0}}, a} + bw;
  endfunction
endpackage

// File: rtl/mash111_acc_chain_if.sv
// Sample strobe / fractional word in, noise-cancellation operands out.
interface mash111_acc_chain_if
  import mash111_acc_chain_pkg::*;
#(
  parameter int W = ACC_W
);
  logic         en;
  logic [W-1:0] frac;
  logic         dither_en;
  nc_op_t       add1;
  nc_op_t       add2;
  nc_op_t       minus;
  logic         valid;

  modport master (
    output en, frac, dither_en,
    input  add1, add2, minus, valid
  );

  modport slave (
    input  en, frac, dither_en,
    output add1, add2, minus, valid
  );
endinterface

// File: rtl/mash111_acc_chain_acc_stage.sv
// One first-order accumulator: W-bit residue register, carry-out of the add is combinational.
module mash_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic         cin,
  output logic         carry,
  output logic [W-1:0] acc
);
  logic [W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, a} + {{W{1'b0}}, cin};
  assign carry = sum[W];

  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= sum[W-1:0];
  end
endmodule

// File: rtl/mash111_acc_chain.sv
// Pipelined MASH 1-1-1 chain: three accumulators, carry delay lines, NC operand registers.
module mash111_acc_chain
  import mash111_acc_chain_pkg::*;
#(
  parameter int    P_ACC_WIDTH = ACC_W,
  parameter lfsr_t P_LFSR_SEED = LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst,
  mash111_acc_chain_if.slave  bus
);
  localparam int W = P_ACC_WIDTH;

  logic [STAGES-1:0][W-1:0] acc;
  logic [STAGES-1:0][W-1:0] opnd;
  logic [STAGES-1:0]        cin;
  logic [STAGES-1:0]        carry;
  logic [STAGES-1:0][1:0]   cdly;   // [i][0] = c[n-1], [i][1] = c[n-2]
  lfsr_t                    lfsr;
  nc_ops_t                  ops_d, ops_q;
  logic                     valid_q;

  // Stage k+1 sees the registered residue of stage k, so the chain is pipelined
  assign opnd = {acc[1], acc[0], bus.frac};
  assign cin  = {1'b0, 1'b0, lfsr[0] & bus.dither_en};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mash_acc_stage #(.W(W)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.en),
      .a     (opnd[i]),
      .cin   (cin[i]),
      .carry (carry[i]),
      .acc   (acc[i])
    );
  end

  always_comb begin
    ops_d       = '0;
    ops_d.add1  = carry_sum(cdly[0][1], cdly[1][0], 1'b0);
    ops_d.add2  = carry_sum(carry[2],   cdly[2][1], 1'b0);
    ops_d.minus = carry_sum(cdly[1][1], cdly[2][0], 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdly    <= '0;
      ops_q   <= '0;
      valid_q <= 1'b0;
      lfsr    <= P_LFSR_SEED;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        for (int i = 0; i < STAGES; i++) cdly[i] <= {cdly[i][0], carry[i]};
        ops_q <= ops_d;
        lfsr  <= lfsr_next(lfsr);
      end
    end
  end

  assign bus.add1  = ops_q.add1;
  assign bus.add2  = ops_q.add2;
  assign bus.minus = ops_q.minus;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_mash111_acc_chain.sv
// Directed bench for mash111_acc_chain against a carry-history reference model.
module tb_mash111_acc_chain;
  localparam int HMAX = 70000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mash111_acc_chain_if bus ();
  mash111_acc_chain dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: accumulator values as plain integers, carry history by sample index
  longint m_e1, m_e2, m_e3;
  int     m_lfsr;
  int     m_n;
  bit     c1h [HMAX];
  bit     c2h [HMAX];
  bit     c3h [HMAX];
  int     x_a1, x_a2, x_mi;
  bit     x_v;

  function automatic int c1at(int k); return (k < 0) ? 0 : int'(c1h[k]); endfunction
  function automatic int c2at(int k); return (k < 0) ? 0 : int'(c2h[k]); endfunction
  function automatic int c3at(int k); return (k < 0) ? 0 : int'(c3h[k]); endfunction

  task automatic model_reset();
    m_e1 = 0; m_e2 = 0; m_e3 = 0;
    m_lfsr = 'h4A3F;
    m_n = 0;
    x_a1 = 0; x_a2 = 0; x_mi = 0; x_v = 0;
  endtask

  task automatic model_sample(input int f, input bit dth);
    longint s1, s2, s3;
    int d, fb;
    d  = dth ? (m_lfsr & 1) : 0;
    s1 = m_e1 + f + d;
    s2 = m_e2 + m_e1;
    s3 = m_e3 + m_e2;
    c1h[m_n] = (s1 >= 65536);
    c2h[m_n] = (s2 >= 65536);
    c3h[m_n] = (s3 >= 65536);
    m_e1 = s1 % 65536; m_e2 = s2 % 65536; m_e3 = s3 % 65536;
    x_a1 = c1at(m_n-2) + c2at(m_n-1);
    x_a2 = c3at(m_n)   + c3at(m_n-2);
    x_mi = c2at(m_n-2) + 2*c3at(m_n-1);
    x_v  = 1;
    fb     = (m_lfsr ^ (m_lfsr >> 1)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 14);
    m_n++;
  endtask

  // one clock: drive, advance model alongside the DUT, compare just after the edge
  task automatic step(input bit r, input bit e, input logic [15:0] f, input bit dth);
    logic [12:0] got, want;
    rst = r; bus.en = e; bus.frac = f; bus.dither_en = dth;
    @(posedge clk); #1;
    cyc++;
    if (r) model_reset();
    else if (e) model_sample(int'(f), dth);
    else x_v = 0;
    got  = {bus.valid, bus.add1, bus.add2, bus.minus};
    want = {x_v, 4'(x_a1), 4'(x_a2), 4'(x_mi)};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model cyc %0d: dut v=%0b a1=%0d a2=%0d mi=%0d, expected v=%0b a1=%0d a2=%0d mi=%0d",
               cyc, bus.valid, bus.add1, bus.add2, bus.minus, x_v, x_a1, x_a2, x_mi);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_8000_literal(input string tag);
    int a1l [4] = '{0, 0, 0, 1};
    int a2l [4] = '{0, 0, 0, 1};
    int mil [4] = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 16'h8000, 0);
      chk({tag, "_add1"},  bus.add1,  4'(a1l[k]));
      chk({tag, "_add2"},  bus.add2,  4'(a2l[k]));
      chk({tag, "_minus"}, bus.minus, 4'(mil[k]));
      chk({tag, "_valid"}, {3'b0, bus.valid}, 4'd1);
    end
  endtask

  initial begin
    logic [3:0] h1, h2, hm;
    longint sumy;
    int     range_bad;

    model_reset();
    rst = 1; bus.en = 0; bus.frac = '0; bus.dither_en = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
    chk("reset_valid", {3'b0, bus.valid}, 4'd0);
    chk("reset_add1",  bus.add1,  4'd0);
    chk("reset_minus", bus.minus, 4'd0);

    // all-zero input never produces a carry
    for (int i = 0; i < 20; i++) step(0, 1, 16'h0, 0);
    chk("zero_add2", bus.add2, 4'd0);

    step(1, 0, 16'h0, 0);
    run_8000_literal("half");
    for (int i = 0; i < 20; i++) step(0, 1, 16'h8000, 0);

    // strobe gap: outputs frozen, valid low, sequence resumes unbroken
    h1 = bus.add1; h2 = bus.add2; hm = bus.minus;
    for (int i = 0; i < 10; i++) step(0, 0, 16'h8000, 0);
    chk("gap_valid", {3'b0, bus.valid}, 4'd0);
    chk("gap_add1",  bus.add1,  h1);
    chk("gap_add2",  bus.add2,  h2);
    chk("gap_minus", bus.minus, hm);
    for (int i = 0; i < 20; i++) step(0, 1, 16'h8000, 0);

    // single-cycle reset with i_en high mid-run
    step(1, 1, 16'h8000, 0);
    chk("rst_mid_valid", {3'b0, bus.valid}, 4'd0);
    chk("rst_mid_add1",  bus.add1, 4'd0);
    run_8000_literal("restart");

    // full-scale word: c1 = 0,1,..; c2[2] = 1 (FFFF+FFFE); c3[3] = 1 (FFFF+FFFD)
    step(1, 0, 16'h0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 16'hFFFF, 0);
    chk("ffff_add1_s3",  bus.add1,  4'd2);
    chk("ffff_add2_s3",  bus.add2,  4'd1);
    chk("ffff_minus_s3", bus.minus, 4'd0);
    for (int i = 0; i < 30; i++) step(0, 1, 16'hFFFF, 0);

    // mid-run word change with an irregular strobe, dither toggling
    for (int i = 0; i < 60; i++) step(0, (i % 3) != 1, 16'h0F0F + 16'(i*97), i[2]);

    // long dithered run: bit-accurate per sample plus mean/range bounds
    step(1, 0, 16'h0, 0);
    sumy = 0; range_bad = 0;
    for (int i = 0; i < 65536; i++) begin
      step(0, 1, 16'h1234, 1);
      sumy += longint'(bus.add1) + longint'(bus.add2) - longint'(bus.minus);
      if (bus.add1 > 2 || bus.add2 > 2 || bus.minus > 3) range_bad++;
    end
    checks++;
    if (range_bad != 0) begin
      errors++;
      $display("FAIL dither_range: %0d out-of-range samples, expected 0", range_bad);
    end
    checks++;
    if (sumy < 4660 - 8 || sumy > 4660 + 8) begin
      errors++;
      $display("FAIL dither_mean: sum(y)=%0d expected 4660 +/- 8", sumy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
